// File: rtl/vigenere_stream_cipher_if.sv
// Host-side bundle for the Vigenere engine: key loading, input byte stream, output byte stream.
// master = host/testbench driving bytes and keys; slave = the cipher engine.
interface vigenere_stream_cipher_if #(
   parameter int KEY_MAX_LEN = 16,
   parameter int KEY_IDX_W   = $clog2(KEY_MAX_LEN + 1)
);
   logic                 key_clear;
   logic                 key_wr;
   logic [7:0]           key_wr_data;
   logic                 key_commit;
   logic [KEY_IDX_W-1:0] key_len;
   logic                 mode;
   logic                 in_valid;
   logic                 in_ready;
   logic [7:0]           in_data;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [7:0]           out_data;
   logic                 out_last;
   logic                 err;

   modport master (
      output key_clear, key_wr, key_wr_data, key_commit, mode,
      output in_valid, in_data, in_last, out_ready,
      input  key_len, in_ready, out_valid, out_data, out_last, err
   );

   modport slave (
      input  key_clear, key_wr, key_wr_data, key_commit, mode,
      input  in_valid, in_data, in_last, out_ready,
      output key_len, in_ready, out_valid, out_data, out_last, err
   );
endinterface

// File: rtl/vigenere_stream_cipher.sv
// Byte-wise Vigenere encrypt/decrypt with runtime key; one registered cycle of latency.
// in_ready drops only while a result is held unaccepted; a drained output slot accepts a new byte the same cycle.
module vigenere_stream_cipher #(
   parameter int KEY_MAX_LEN = 16
) (
   input logic                    clk,
   input logic                    rst,
   vigenere_stream_cipher_if.slave bus
);
   localparam int KEY_IDX_W = $clog2(KEY_MAX_LEN + 1);
   localparam int KEY_AW    = (KEY_MAX_LEN > 1) ? $clog2(KEY_MAX_LEN) : 1;
   localparam logic [KEY_IDX_W-1:0] KEY_MAX = KEY_IDX_W'(KEY_MAX_LEN);
   localparam logic [KEY_IDX_W-1:0] IDX_ONE = KEY_IDX_W'(1);

   typedef enum logic [1:0] {S_NOKEY, S_KEYLOAD, S_RUN} state_t;

   state_t               state_q;
   logic [7:0]           key_q [2**KEY_AW];
   logic [KEY_IDX_W-1:0] key_len_q, key_len_d;
   logic [KEY_IDX_W-1:0] key_idx_q, key_idx_d;
   logic                 msg_active_q, mode_q;
   logic                 out_valid_q, out_last_q, err_q;
   logic [7:0]           out_data_q, out_data_d, key_byte;
   logic                 in_ready, accept, mode_eff, key_full, key_wr_ok;

   assign key_full  = (key_len_q == KEY_MAX);
   assign key_wr_ok = (state_q == S_KEYLOAD) && bus.key_wr && !bus.key_clear && !key_full;
   assign key_len_d = key_len_q + KEY_IDX_W'(key_wr_ok);

   assign in_ready = (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   // Mode is fixed by the first beat of a message; later beats reuse the latched copy.
   assign mode_eff   = msg_active_q ? mode_q : bus.mode;
   assign key_byte   = key_q[key_idx_q[KEY_AW-1:0]];
   assign out_data_d = mode_eff ? (bus.in_data - key_byte) : (bus.in_data + key_byte);
   assign key_idx_d  = (bus.in_last || (key_idx_q == key_len_q - IDX_ONE)) ? '0 : key_idx_q + IDX_ONE;

   always_ff @(posedge clk) begin
      if (key_wr_ok) begin
         key_q[key_len_q[KEY_AW-1:0]] <= bus.key_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_NOKEY;
         key_len_q    <= '0;
         key_idx_q    <= '0;
         msg_active_q <= 1'b0;
         mode_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= 8'd0;
         out_last_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         if (accept) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= out_data_d;
            out_last_q   <= bus.in_last;
            key_idx_q    <= key_idx_d;
            msg_active_q <= !bus.in_last;
            if (!msg_active_q) begin
               mode_q <= bus.mode;
            end
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            S_NOKEY: begin
               if (bus.key_clear) begin
                  state_q   <= S_KEYLOAD;
                  key_len_q <= '0;
                  err_q     <= 1'b0;
               end
            end
            S_KEYLOAD: begin
               if (bus.key_clear) begin
                  key_len_q <= '0;
                  err_q     <= 1'b0;
               end else begin
                  key_len_q <= key_len_d;
                  if (bus.key_wr && key_full) begin
                     err_q <= 1'b1;
                  end
                  if (bus.key_commit) begin
                     state_q      <= (key_len_d != '0) ? S_RUN : S_NOKEY;
                     key_idx_q    <= '0;
                     msg_active_q <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               // Rekeying is only safe with nothing in flight; otherwise flag it and carry on.
               if (bus.key_clear) begin
                  if (!msg_active_q && !out_valid_q) begin
                     state_q      <= S_KEYLOAD;
                     key_len_q    <= '0;
                     key_idx_q    <= '0;
                     msg_active_q <= 1'b0;
                     err_q        <= 1'b0;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            default: state_q <= S_NOKEY;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.key_len   = key_len_q;
   assign bus.err       = err_q;
endmodule
